// File: rtl/dmem_mmio_uart_pkg.sv
// Shared constants for the dmem MMIO UART: window decode, register offsets,
// STATUS bit layout and the transmitter state encoding.
package mmio_uart_pkg;

  localparam logic [11:0] MMIO_BASE  = 12'hFF0;
  localparam logic [3:0]  OFF_TXDATA = 4'hC;
  localparam logic [3:0]  OFF_STATUS = 4'hD;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  // PARITY is always part of the encoding; it is only reachable with UART_PARITY_EN.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  function automatic logic in_window(input logic [11:0] addr);
    return addr[11:4] == MMIO_BASE[11:4];
  endfunction

endpackage

// File: rtl/dmem_mmio_uart_fifo.sv
// Synchronous FIFO with combinational head output; a push while full is
// accepted only when a pop happens in the same cycle.
module mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dmem_mmio_uart.sv
// UART transmitter mapped at the top of the dmem address space (0xFF0-0xFFF).
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
//
// Handshake: there is no valid/ready pair on the CPU side. A store (wren=1)
// is taken at the edge it is presented; a load's result appears on q_cpu one
// cycle after the address, matching dmem's latency. The FIFO push from the CPU
// is accepted when not full, or when full and the FSM pops in the same cycle.
module dmem_mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_cpu,
  output logic        dmem_wren,
  input  logic [31:0] q_dmem,
  output logic        tx,
  output logic        tx_busy,
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  logic          win;
  logic [3:0]    offset;
  logic          push_req;
  logic          status_wr;
  logic          ovf_event;
  logic          unused_data;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  uart_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
  logic          hit_q, hit_d;
  logic [31:0]   reg_q, reg_d;
  logic [31:0]   status_vec;
  logic          bit_done;

  assign win         = in_window(address_dmem);
  assign offset      = address_dmem[3:0];
  assign dmem_wren   = wren & ~win;
  assign push_req    = wren & win & (offset == OFF_TXDATA);
  assign status_wr   = wren & win & (offset == OFF_STATUS);
  assign unused_data = ^data[31:8];

  mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_done = (timer_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    fifo_pop  = 1'b0;
    if (state_q != S_IDLE) begin
      timer_d = bit_done ? '0 : timer_q + TW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          parity_d = ^fifo_dout;
          timer_d  = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            parity_d = ^fifo_dout;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is registered from next-state values so tx never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // A dropped push sets overflow even when the same cycle writes STATUS.
  assign ovf_event = push_req & fifo_full & ~fifo_pop;

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (status_wr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    status_vec                          = '0;
    status_vec[STAT_FULL]               = fifo_full;
    status_vec[STAT_EMPTY]              = fifo_empty;
    status_vec[STAT_BUSY]               = (state_q != S_IDLE);
    status_vec[STAT_OVF]                = overflow_q;
    status_vec[STAT_COUNT_LSB +: 4]     = 4'(fifo_count);
  end

  always_comb begin
    hit_d = win;
    reg_d = (win && offset == OFF_STATUS) ? status_vec : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      hit_q      <= 1'b0;
      reg_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      hit_q      <= hit_d;
      reg_q      <= reg_d;
    end
  end

  assign q_cpu     = hit_q ? reg_q : q_dmem;
  assign tx        = tx_q;
  assign tx_busy   = (state_q != S_IDLE) | ~fifo_empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Directed bench for dmem_mmio_uart: CPU read results and serial frames are
// queued as expectations when issued and checked by independent monitors.
module tb_dmem_mmio_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = 12'h000;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_cpu;
  logic        dmem_wren;
  logic [31:0] q_dmem = 32'h1234_5678;
  logic        tx;
  logic        tx_busy;
  logic [2:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic        rd_req = 1'b0;
  logic        mon_en = 1'b1;

  logic [31:0] exp_q[$];
  string       exp_name_q[$];
  logic [7:0]  tx_exp_q[$];

  dmem_mmio_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address),
    .data         (data),
    .wren         (wren),
    .q_cpu        (q_cpu),
    .dmem_wren    (dmem_wren),
    .q_dmem       (q_dmem),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a;
    data    = d;
    wren    = 1'b1;
    rd_req  = 1'b0;
    #1;
    check("dmem_wren", {31'b0, dmem_wren}, {31'b0, (a[11:4] != 8'hFF)});
  endtask

  task automatic cpu_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    @(negedge clock);
    address = a;
    wren    = 1'b0;
    rd_req  = 1'b1;
    exp_q.push_back(exp);
    exp_name_q.push_back(name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      address = 12'h000;
      wren    = 1'b0;
      rd_req  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit, output int cycles);
    cycles = 0;
    while (tx_busy && cycles < limit) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    if (tx_busy) check("busy_timeout", {31'b0, tx_busy}, 32'd0);
  endtask

  // ---------------- read monitor ----------------
  always @(posedge clock) begin
    if (rd_req) begin
      #1;
      if (exp_q.size() == 0) begin
        check("read_unexpected", 32'd1, 32'd0);
      end else begin
        check(exp_name_q.pop_front(), q_cpu, exp_q.pop_front());
      end
    end
  end

  // ---------------- serial monitor ----------------
  initial begin
    logic [7:0] rx;
    logic       par;
    logic [7:0] exp_b;
    par = 1'b0;
    forever begin
      @(negedge tx);
      if (mon_en && !reset) begin
        repeat (CPB / 2) @(posedge clock);
        #1;
        check("rx_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clock);
          #1;
          rx[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(posedge clock);
        #1;
        par = tx;
`endif
        repeat (CPB) @(posedge clock);
        #1;
        check("rx_stop", {31'b0, tx}, 32'd1);
        if (tx_exp_q.size() == 0) begin
          check("rx_unexpected", {24'b0, rx}, 32'd0);
        end else begin
          exp_b = tx_exp_q.pop_front();
          check("rx_byte", {24'b0, rx}, {24'b0, exp_b});
`ifdef UART_PARITY_EN
          check("rx_parity", {31'b0, par}, {31'b0, ^exp_b});
`endif
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   cyc;
    logic bad;

    // Reset and idle
    repeat (3) @(negedge clock);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, tx_busy}, 32'd0);
    check("reset_state", {29'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    idle(100);
    check("idle_tx", {31'b0, tx}, 32'd1);
    check("idle_busy", {31'b0, tx_busy}, 32'd0);
    cpu_read(12'hFFD, 32'h0000_0002, "status_reset");

    // Pass-through and unused window registers
    cpu_write(12'h010, 32'h0000_0012);
    cpu_write(12'hFF3, 32'($urandom_range(0, 255)));
    cpu_read(12'h010, 32'h1234_5678, "dmem_read");
    cpu_read(12'hFF3, 32'h0, "window_other_read");
    cpu_read(12'hFFC, 32'h0, "txdata_read");
    cpu_read(12'hFFD, 32'h0000_0002, "status_after_dmem");
    idle(2);

    // Single frame 0xA5: start timing and frame length
    tx_exp_q.push_back(8'hA5);
    @(negedge clock);
    address = 12'hFFC;
    data    = 32'h0000_00A5;
    wren    = 1'b1;
    #1;
    check("dmem_wren_txdata", {31'b0, dmem_wren}, 32'd0);
    @(posedge clock);
    #1;
    check("tx_after_e0", {31'b0, tx}, 32'd1);
    check("busy_after_e0", {31'b0, tx_busy}, 32'd1);
    @(negedge clock);
    address = 12'h000;
    wren    = 1'b0;
    @(posedge clock);
    #1;
    check("tx_after_e1", {31'b0, tx}, 32'd0);
    wait_idle(200, cyc);
    check("frame_len", 32'(cyc), 32'(FRAME));
    check("tx_after_frame", {31'b0, tx}, 32'd1);
    cpu_read(12'hFFD, 32'h0000_0002, "status_after_frame");
    idle(2);

    // Burst of 10 writes: 9 accepted, 10th overflows
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_exp_q.push_back(8'(8'h30 + i));
      cpu_write(12'hFFC, 32'(8'h30 + i));
    end
    cpu_read(12'hFFD, 32'h0000_008D, "status_overflow");
    cpu_write(12'hFFD, 32'h0);
    cpu_read(12'hFFD, 32'h0000_0085, "status_overflow_cleared");
    idle(1);
    wait_idle(9 * FRAME + 50, cyc);
    idle(4);

    // Two queued bytes: second start bit immediately follows first stop bit
    tx_exp_q.push_back(8'h07);
    tx_exp_q.push_back(8'h5A);
    cpu_write(12'hFFC, 32'h0000_0007);
    cpu_write(12'hFFC, 32'h0000_005A);
    @(posedge clock);
    #1;
    check("b2b_first_start", {31'b0, tx}, 32'd0);
    @(negedge clock);
    address = 12'h000;
    wren    = 1'b0;
    repeat (FRAME - 1) @(posedge clock);
    #1;
    check("b2b_last_stop", {31'b0, tx}, 32'd1);
    @(posedge clock);
    #1;
    check("b2b_second_start", {31'b0, tx}, 32'd0);
    wait_idle(FRAME + 20, cyc);
    check("b2b_second_len", 32'(cyc), 32'(FRAME));
    idle(4);

    // Reset in the middle of a data bit, with a second byte still queued
    mon_en = 1'b0;
    cpu_write(12'hFFC, 32'h0000_003C);
    cpu_write(12'hFFC, 32'h0000_00C3);
    idle(10);
    check("tx_before_reset", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_mid_tx", {31'b0, tx}, 32'd1);
    check("reset_mid_busy", {31'b0, tx_busy}, 32'd0);
    check("reset_mid_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cpu_read(12'hFFD, 32'h0000_0002, "status_after_reset");
    idle(1);
    bad = 1'b0;
    repeat (60) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    check("no_resume_after_reset", {31'b0, bad}, 32'd0);

    idle(5);
    check("read_queue_drained", 32'(exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
